// File: rtl/delta_stress_tracker.sv
// delta_stress_tracker
//   Compares each qualified stress-status sample against the previous accepted
//   sample. It reports fall/rise pulses, the change magnitude, a saturating run
//   length of "equal" comparisons, a stable flag and a held trend direction.
//   A change whose magnitude is at most DEADBAND counts as equal.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   clear        synchronous restart; takes priority over sample_valid
//   sample_valid status carries a new sample this cycle
//   status       unsigned stress sample, WIDTH bits
//   decreased    1-cycle pulse: last sample fell by more than DEADBAND
//   increased    1-cycle pulse: last sample rose by more than DEADBAND
//   stable       stable_count >= STABLE_LEN
//   delta        |status - prev| of the last comparison
//   stable_count saturating run of equal comparisons
//   trend        00 UNKNOWN, 01 FALLING, 10 RISING, 11 STABLE
module delta_stress_tracker #(
   parameter int WIDTH      = 3,
   parameter int STABLE_LEN = 2,
   parameter int DEADBAND   = 0,
   parameter int CNT_W      = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] status,
   output logic             decreased,
   output logic             increased,
   output logic             stable,
   output logic [WIDTH-1:0] delta,
   output logic [CNT_W-1:0] stable_count,
   output logic [1:0]       trend
);

   typedef enum logic [1:0] {
      T_UNKNOWN = 2'b00,
      T_FALLING = 2'b01,
      T_RISING  = 2'b10,
      T_STABLE  = 2'b11
   } trend_e;

   localparam logic [WIDTH:0]   DB      = (WIDTH+1)'(DEADBAND);
   localparam logic [CNT_W-1:0] SL      = CNT_W'(STABLE_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] prev_q, prev_d;
   logic             have_q, have_d;
   logic             dec_q, dec_d;
   logic             inc_q, inc_d;
   logic             stable_q, stable_d;
   logic [WIDTH-1:0] delta_q, delta_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   trend_e           trend_q, trend_d;

   // One extra bit makes the difference exact across the full unsigned range,
   // so 0 -> max and max -> 0 never wrap.
   logic signed [WIDTH:0] diff, diff_neg;
   logic        [WIDTH:0] mag;

   always_comb begin
      diff     = $signed({1'b0, status}) - $signed({1'b0, prev_q});
      diff_neg = -diff;
      mag      = diff[WIDTH] ? $unsigned(diff_neg) : $unsigned(diff);
   end

   always_comb begin
      prev_d   = prev_q;
      have_d   = have_q;
      dec_d    = 1'b0;
      inc_d    = 1'b0;
      stable_d = stable_q;
      delta_d  = delta_q;
      cnt_d    = cnt_q;
      trend_d  = trend_q;

      if (clear) begin
         prev_d   = '0;
         have_d   = 1'b0;
         stable_d = 1'b0;
         delta_d  = '0;
         cnt_d    = '0;
         trend_d  = T_UNKNOWN;
      end else if (sample_valid) begin
         prev_d = status;
         have_d = 1'b1;
         // The first sample after restart only seeds the reference.
         if (have_q) begin
            delta_d = mag[WIDTH-1:0];
            if (mag <= DB) begin
               cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
               stable_d = (cnt_d >= SL);
               if (stable_d) trend_d = T_STABLE;
            end else if (diff[WIDTH]) begin
               dec_d    = 1'b1;
               cnt_d    = '0;
               stable_d = 1'b0;
               trend_d  = T_FALLING;
            end else begin
               inc_d    = 1'b1;
               cnt_d    = '0;
               stable_d = 1'b0;
               trend_d  = T_RISING;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_q   <= '0;
         have_q   <= 1'b0;
         dec_q    <= 1'b0;
         inc_q    <= 1'b0;
         stable_q <= 1'b0;
         delta_q  <= '0;
         cnt_q    <= '0;
         trend_q  <= T_UNKNOWN;
      end else begin
         prev_q   <= prev_d;
         have_q   <= have_d;
         dec_q    <= dec_d;
         inc_q    <= inc_d;
         stable_q <= stable_d;
         delta_q  <= delta_d;
         cnt_q    <= cnt_d;
         trend_q  <= trend_d;
      end
   end

   assign decreased    = dec_q;
   assign increased    = inc_q;
   assign stable       = stable_q;
   assign delta        = delta_q;
   assign stable_count = cnt_q;
   assign trend        = trend_q;

endmodule
